// File: rtl/piano_pkg.sv
// Shared constants, event payload and clog2 helper for the piano key path.
package piano_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  localparam int unsigned N_KEYS = 8;
  localparam int unsigned NOTE_W = clog2(N_KEYS);

  typedef struct packed {
    logic              press;
    logic [NOTE_W-1:0] note;
  } key_event_t;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO of key events; head is read straight from storage.
module event_fifo
  import piano_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 push,
  input  key_event_t           push_data,
  input  logic                 pop,
  output key_event_t           head,
  output logic                 full,
  output logic                 empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  key_event_t        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  // Pop on empty is dropped; push on full only goes through alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into a round-robin-serialized press/release event stream.
// Optional KEY_EVENT_ACTIVE_NOTE_EN adds the monophonic ACTIVE_VALID/ACTIVE_NOTE tracker.
module key_event_queue #(
  parameter int unsigned N_KEYS = piano_pkg::N_KEYS,
  parameter int unsigned NOTE_W = piano_pkg::NOTE_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic [N_KEYS-1:0]               KEYS,
  output logic                            EVT_VALID,
  input  logic                            EVT_READY,
  output logic                            EVT_PRESS,
  output logic [NOTE_W-1:0]               EVT_NOTE,
  output logic [piano_pkg::clog2(DEPTH):0] EVT_COUNT
`ifdef KEY_EVENT_ACTIVE_NOTE_EN
  ,
  output logic                            ACTIVE_VALID,
  output logic [NOTE_W-1:0]               ACTIVE_NOTE
`endif
);

  logic [N_KEYS-1:0]     prev_q;
  logic [N_KEYS-1:0]     pending_q;
  logic [N_KEYS-1:0]     key_edge;
  logic [N_KEYS-1:0]     grant;
  logic [NOTE_W-1:0]     rr_ptr_q;
  logic [NOTE_W-1:0]     grant_idx;
  logic                  grant_vld;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  int unsigned           scan_idx;
  piano_pkg::key_event_t push_evt;
  piano_pkg::key_event_t head_evt;

  assign key_edge  = KEYS ^ prev_q;
  assign pop       = EVT_VALID & EVT_READY;

  // Round-robin scan from rr_ptr upward with wrap; held off only when full with no pop.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    if (!fifo_full || pop) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        scan_idx = (32'(rr_ptr_q) + i) % N_KEYS;
        if (!grant_vld && pending_q[NOTE_W'(scan_idx)]) begin
          grant_vld = 1'b1;
          grant_idx = NOTE_W'(scan_idx);
        end
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
    push_evt.press = prev_q[grant_idx];
    push_evt.note  = grant_idx;
  end

  // Unserved opposite edges on one key cancel through the XOR.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_q    <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      prev_q    <= KEYS;
      pending_q <= (pending_q & ~grant) ^ key_edge;
      if (grant_vld)
        rr_ptr_q <= (grant_idx == NOTE_W'(N_KEYS - 1)) ? '0 : grant_idx + NOTE_W'(1);
    end
  end

  event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .push     (grant_vld),
    .push_data(push_evt),
    .pop      (pop),
    .head     (head_evt),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (EVT_COUNT)
  );

  assign EVT_VALID = ~fifo_empty;
  assign EVT_PRESS = head_evt.press;
  assign EVT_NOTE  = head_evt.note;

`ifdef KEY_EVENT_ACTIVE_NOTE_EN
  logic [N_KEYS-1:0] rising;
  logic [NOTE_W-1:0] hi_idx;

  assign rising = KEYS & ~prev_q;

  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < N_KEYS; i++)
      if (rising[NOTE_W'(i)]) hi_idx = NOTE_W'(i);
  end

  // Newest highest press wins; drop validity once the tracked key is released.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ACTIVE_VALID <= 1'b0;
      ACTIVE_NOTE  <= '0;
    end else if (|rising) begin
      ACTIVE_VALID <= 1'b1;
      ACTIVE_NOTE  <= hi_idx;
    end else if (!KEYS[ACTIVE_NOTE]) begin
      ACTIVE_VALID <= 1'b0;
    end
  end
`endif

endmodule
